ebus_io_seq: RTL and testbench

//  EBUS master sequencer for EBOX I/O instructions (CONO/CONI/DATAO/DATAI). Drives device

---
 rtl/ebus_pkg.sv | 37 +++
 rtl/ebus_timer.sv | 25 ++
 rtl/ebus_io_seq.sv | 163 ++++++++++++++++
 tb/tb_ebus_io_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, sequencer states and request payload.
package ebus_pkg;

   localparam int unsigned FUNC_W = 3;
   localparam int unsigned DEV_W  = 7;
   localparam int unsigned DS_W   = 8;
   localparam int unsigned DATA_W = 36;

   localparam logic [FUNC_W-1:0] EBUS_CONO  = 3'd0;
   localparam logic [FUNC_W-1:0] EBUS_CONI  = 3'd1;
   localparam logic [FUNC_W-1:0] EBUS_DATAO = 3'd2;
   localparam logic [FUNC_W-1:0] EBUS_DATAI = 3'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DEMAND,
      ST_RELEASE,
      ST_DONE
   } ebusState_t;

   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [DEV_W-1:0]  devNum;
      logic [DATA_W-1:0] wrData;
   } ebusReq_t;

   function automatic logic isLegal(input logic [FUNC_W-1:0] f);
      return f <= EBUS_DATAI;
   endfunction

   // CONI/DATAI return data from the device; CONO/DATAO drive it.
   function automatic logic isRead(input logic [FUNC_W-1:0] f);
      return (f == EBUS_CONI) || (f == EBUS_DATAI);
   endfunction

endpackage

// File: rtl/ebus_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ebus_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] loadVal,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= loadVal;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign expired = (count == '0);

endmodule

// File: rtl/ebus_io_seq.sv
// EBUS master sequencer for EBOX I/O instructions: select, demand, release, report.
module ebus_io_seq
   import ebus_pkg::*;
#(
   parameter int unsigned DS_SETUP = 2,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  func,
   input  logic [6:0]  devNum,
   input  logic [35:0] wrData,
   input  logic        piBusy,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        illegal,
   output logic [35:0] rdData,
   output logic [7:0]  ds,
   output logic        dsStrobe,
   output logic [2:0]  ebusF,
   output logic        ebusDemand,
   input  logic        ebusXfer,
   output logic        ebusDrive,
   output logic [35:0] ebusOut,
   input  logic [35:0] ebusIn
);

   localparam int unsigned CNT_MAX = (TIMEOUT > DS_SETUP) ? TIMEOUT : DS_SETUP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

   ebusState_t       state;
   ebusState_t       stateNext;
   ebusReq_t         req;
   ebusReq_t         reqSel;
   logic             reqCapture;
   logic             tmrLoad;
   logic [CNT_W-1:0] tmrVal;
   logic             tmrExpired;
   logic             timeoutNext;
   logic             illegalNext;
   logic             rdLatch;
   logic             rdClear;
   logic             busActive;
   logic             writeActive;

   ebus_timer #(.WIDTH(CNT_W)) uTimer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmrLoad),
      .loadVal (tmrVal),
      .expired (tmrExpired)
   );

   // In IDLE the live request feeds the outputs so the first SETUP cycle is already valid.
   always_comb begin
      reqSel = req;
      if (state == ST_IDLE) begin
         reqSel.func   = func;
         reqSel.devNum = devNum;
         reqSel.wrData = wrData;
      end
   end

   always_comb begin
      stateNext   = state;
      reqCapture  = 1'b0;
      tmrLoad     = 1'b0;
      tmrVal      = '0;
      timeoutNext = 1'b0;
      illegalNext = 1'b0;
      rdLatch     = 1'b0;
      rdClear     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (!isLegal(func)) begin
                  stateNext   = ST_DONE;
                  illegalNext = 1'b1;
               end else if (!piBusy) begin
                  stateNext  = ST_SETUP;
                  reqCapture = 1'b1;
                  tmrLoad    = 1'b1;
                  tmrVal     = CNT_W'(DS_SETUP - 1);
               end
            end
         end
         ST_SETUP: begin
            if (tmrExpired) begin
               stateNext = ST_DEMAND;
               tmrLoad   = 1'b1;
               tmrVal    = CNT_W'(TIMEOUT - 1);
            end
         end
         ST_DEMAND: begin
            // A transfer arriving on the expiry cycle still completes normally.
            if (ebusXfer) begin
               stateNext = ST_RELEASE;
               rdLatch   = isRead(req.func);
               tmrLoad   = 1'b1;
               tmrVal    = CNT_W'(TIMEOUT - 1);
            end else if (tmrExpired) begin
               stateNext   = ST_DONE;
               timeoutNext = 1'b1;
               rdClear     = 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!ebusXfer) begin
               stateNext = ST_DONE;
            end else if (tmrExpired) begin
               stateNext   = ST_DONE;
               timeoutNext = 1'b1;
            end
         end
         ST_DONE:  stateNext = ST_IDLE;
         default:  stateNext = ST_IDLE;
      endcase
   end

   assign busActive   = (stateNext == ST_SETUP) || (stateNext == ST_DEMAND) ||
                        (stateNext == ST_RELEASE);
   assign writeActive = busActive && !isRead(reqSel.func);

   // State and all outputs registered from the next-state decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         req        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         illegal    <= 1'b0;
         rdData     <= '0;
         ds         <= '0;
         dsStrobe   <= 1'b0;
         ebusF      <= '0;
         ebusDemand <= 1'b0;
         ebusDrive  <= 1'b0;
         ebusOut    <= '0;
      end else begin
         state      <= stateNext;
         if (reqCapture)
            req <= reqSel;
         busy       <= (stateNext != ST_IDLE);
         done       <= (stateNext == ST_DONE);
         timeout    <= timeoutNext;
         illegal    <= illegalNext;
         if (rdClear)
            rdData <= '0;
         else if (rdLatch)
            rdData <= ebusIn;
         ds         <= busActive ? {reqSel.devNum, 1'b0} : '0;
         ebusF      <= busActive ? reqSel.func : '0;
         dsStrobe   <= (stateNext == ST_SETUP);
         ebusDemand <= (stateNext == ST_DEMAND);
         ebusDrive  <= writeActive;
         ebusOut    <= writeActive ? reqSel.wrData : '0;
      end
   end

endmodule

// File: tb/tb_ebus_io_seq.sv
// Self-checking bench for ebus_io_seq: scoreboard of completions plus cycle-exact bus checks.
module tb_ebus_io_seq;
   import ebus_pkg::*;

   localparam int unsigned DS_SETUP = 2;
   localparam int unsigned TIMEOUT  = 64;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  func;
   logic [6:0]  devNum;
   logic [35:0] wrData;
   logic        piBusy;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        illegal;
   logic [35:0] rdData;
   logic [7:0]  ds;
   logic        dsStrobe;
   logic [2:0]  ebusF;
   logic        ebusDemand;
   logic        ebusXfer;
   logic        ebusDrive;
   logic [35:0] ebusOut;
   logic [35:0] ebusIn;

   ebus_io_seq #(.DS_SETUP(DS_SETUP), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .func       (func),
      .devNum     (devNum),
      .wrData     (wrData),
      .piBusy     (piBusy),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .illegal    (illegal),
      .rdData     (rdData),
      .ds         (ds),
      .dsStrobe   (dsStrobe),
      .ebusF      (ebusF),
      .ebusDemand (ebusDemand),
      .ebusXfer   (ebusXfer),
      .ebusDrive  (ebusDrive),
      .ebusOut    (ebusOut),
      .ebusIn     (ebusIn)
   );

   typedef struct {
      logic        expTimeout;
      logic        expIllegal;
      logic [35:0] expRd;
      int          doneCyc;
   } sbEntry_t;

   sbEntry_t    sb[$];
   sbEntry_t    monE;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          strobeCnt = 0;
   int          strobe0;
   int          devMode = 0;   // 0: ack after ackDelay, 1: never ack, 2: ack stuck high
   int          ackDelay = 0;
   int          demCnt = 0;
   logic        stuck;
   logic [35:0] devData = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (dsStrobe) strobeCnt <= strobeCnt + 1;
   always @(posedge clk) demCnt <= ebusDemand ? demCnt + 1 : 0;
   always @(posedge clk) begin
      if (reset || done)
         stuck <= 1'b0;
      else if (devMode == 2 && ebusDemand)
         stuck <= 1'b1;
   end

   // Device model answering the demand.
   always_comb begin
      case (devMode)
         0:       ebusXfer = ebusDemand && (demCnt >= ackDelay);
         2:       ebusXfer = ebusDemand || stuck;
         default: ebusXfer = 1'b0;
      endcase
   end
   assign ebusIn = devData;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, ".busy"},       64'(busy),       0);
      check({tag, ".done"},       64'(done),       0);
      check({tag, ".timeout"},    64'(timeout),    0);
      check({tag, ".illegal"},    64'(illegal),    0);
      check({tag, ".rdData"},     64'(rdData),     0);
      check({tag, ".ds"},         64'(ds),         0);
      check({tag, ".dsStrobe"},   64'(dsStrobe),   0);
      check({tag, ".ebusF"},      64'(ebusF),      0);
      check({tag, ".ebusDemand"}, 64'(ebusDemand), 0);
      check({tag, ".ebusDrive"},  64'(ebusDrive),  0);
      check({tag, ".ebusOut"},    64'(ebusOut),    0);
   endtask

   // Drive one start cycle and record the expected completion relative to it.
   task automatic issue(input logic [2:0] f, input logic [6:0] d, input logic [35:0] w,
                        input logic expTo, input logic expIll, input logic [35:0] expRd,
                        input int lat);
      sbEntry_t e;
      start  = 1'b1;
      func   = f;
      devNum = d;
      wrData = w;
      e.expTimeout = expTo;
      e.expIllegal = expIll;
      e.expRd      = expRd;
      e.doneCyc    = cyc + lat;
      sb.push_back(e);
      tick();
      start  = 1'b0;
      func   = 3'd6;
      devNum = 7'h7f;
      wrData = '1;
   endtask

   task automatic waitIdle(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0 && !busy) return;
         tick();
      end
      check({tag, ".waitIdleBound"}, 1, 0);
      sb.delete();
   endtask

   // Completion scoreboard and always-true bus properties.
   always @(negedge clk) begin
      if (!reset) begin
         check("dsBit7", 64'(ds[7]), 0);
         if (!ebusDrive) check("ebusOutGate", 64'(ebusOut), 0);
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpectedDone", 1, 0);
            end else begin
               monE = sb.pop_front();
               check("doneCycle", 64'(cyc),     64'(monE.doneCyc));
               check("timeout",   64'(timeout), 64'(monE.expTimeout));
               check("illegal",   64'(illegal), 64'(monE.expIllegal));
               check("rdData",    64'(rdData),  64'(monE.expRd));
            end
         end
      end
   end

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      func   = '0;
      devNum = '0;
      wrData = '0;
      piBusy = 1'b0;
      tick();
      tick();
      checkAllZero("reset");
      reset = 1'b0;
      tick();

      // DATAI dev 0, ack one cycle after demand
      devMode  = 0;
      ackDelay = 1;
      devData  = 36'o123456701234;
      issue(EBUS_DATAI, 7'o0, 36'o0, 1'b0, 1'b0, 36'o123456701234, 6);
      for (int c = 1; c <= 5; c++) begin
         check("t1.ds",     64'(ds),         0);
         check("t1.ebusF",  64'(ebusF),      64'(EBUS_DATAI));
         check("t1.strobe", 64'(dsStrobe),   64'(c <= 2));
         check("t1.demand", 64'(ebusDemand), 64'(c == 3 || c == 4));
         check("t1.drive",  64'(ebusDrive),  0);
         tick();
      end
      waitIdle("t1");
      check("t1.rdHold", 64'(rdData), 64'(36'o123456701234));

      // CONO dev 012 writes 777, rdData untouched
      ackDelay = 0;
      devData  = 36'o3;
      issue(EBUS_CONO, 7'o12, 36'o777, 1'b0, 1'b0, 36'o123456701234, 5);
      for (int c = 1; c <= 4; c++) begin
         check("t2.ds",      64'(ds),        64'h14);
         check("t2.ebusF",   64'(ebusF),     64'(EBUS_CONO));
         check("t2.drive",   64'(ebusDrive), 1);
         check("t2.ebusOut", 64'(ebusOut),   64'(36'o777));
         tick();
      end
      check("t2.doneDrive", 64'(ebusDrive), 0);
      check("t2.doneDs",    64'(ds),        0);
      waitIdle("t2");

      // CONI with no transfer: demand timeout clears rdData
      devMode = 1;
      issue(EBUS_CONI, 7'o3, 36'o0, 1'b1, 1'b0, 36'o0, 1 + DS_SETUP + TIMEOUT);
      waitIdle("t3");

      // DATAO with transfer stuck high: release timeout
      devMode = 2;
      devData = 36'o555;
      issue(EBUS_DATAO, 7'o4, 36'o4242, 1'b1, 1'b0, 36'o0, 1 + DS_SETUP + 1 + TIMEOUT);
      waitIdle("t4a");
      devMode = 0;

      // Illegal function: immediate done, no bus activity
      strobe0 = strobeCnt;
      issue(3'd5, 7'o1, 36'o0, 1'b0, 1'b1, 36'o0, 1);
      check("t4b.demand", 64'(ebusDemand), 0);
      waitIdle("t4b");
      check("t4b.noStrobe", 64'(strobeCnt - strobe0), 0);

      // PI owns the bus for three cycles while start is held
      devData = 36'o707070707070;
      start   = 1'b1;
      func    = EBUS_DATAI;
      devNum  = 7'o5;
      piBusy  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t5.busy",   64'(busy),     0);
         check("t5.strobe", 64'(dsStrobe), 0);
      end
      piBusy = 1'b0;
      issue(EBUS_DATAI, 7'o5, 36'o0, 1'b0, 1'b0, 36'o707070707070, 5);
      check("t5.strobeGo", 64'(dsStrobe), 1);
      check("t5.ds",       64'(ds),       64'h0a);
      waitIdle("t5");

      // Reset in DEMAND aborts silently; next request runs normally
      devMode = 1;
      issue(EBUS_DATAI, 7'o6, 36'o0, 1'b0, 1'b0, 36'o0, 999);
      tick();
      tick();
      check("t6.inDemand", 64'(ebusDemand), 1);
      reset = 1'b1;
      sb.delete();
      tick();
      checkAllZero("t6.abort");
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t6.noDone", 64'(done), 0);
      end
      devMode = 0;
      devData = 36'o1;
      issue(EBUS_DATAI, 7'o2, 36'o0, 1'b0, 1'b0, 36'o1, 5);
      waitIdle("t6");
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
